// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO access controller: default sizing
// constants and the drain FSM state type.
package fifo_ctrl_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 4;
   localparam int unsigned DEF_ADDR_WIDTH = 2;
   localparam int unsigned DEF_BURST_LEN  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } drain_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin write arbiter. A sole requester wins; on contention
// the requester selected by ptr wins. enable blocks all grants (full/reset).
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   input  logic enable,
   output logic gnt0,
   output logic gnt1
);

   // Purely combinational grant decode; grants are mutually exclusive
   always_comb begin
      gnt0 = enable & req0 & (~req1 | ~ptr);
      gnt1 = enable & req1 & (~req0 |  ptr);
   end

endmodule

// File: rtl/fifo_access_ctrl.sv
// FIFO access controller: arbitrates two writers into a FIFO, tracks its
// occupancy, and drains bursts of up to BURST_LEN words on request.
// Optional macro FIFO_AUTO_DRAIN_EN: also start a burst when the FIFO
// reaches DEPTH-1 words without a drain request.
module fifo_access_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                  inClock,
   input  logic                  inReset,
   input  logic                  inReq0,
   input  logic                  inReq1,
   input  logic [DATA_WIDTH-1:0] inData0,
   input  logic [DATA_WIDTH-1:0] inData1,
   output logic                  outGnt0,
   output logic                  outGnt1,
   input  logic                  inDrainReq,
   output logic                  outFifoWriteEnable,
   output logic [DATA_WIDTH-1:0] outFifoData,
   output logic                  outFifoReadEnable,
   input  logic [DATA_WIDTH-1:0] inFifoData,
   output logic [DATA_WIDTH-1:0] outData,
   output logic                  outValid,
   output logic                  outDone,
   output logic [ADDR_WIDTH:0]   outLevel,
   output logic                  outBusy
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned LW    = ADDR_WIDTH + 1;
   localparam int unsigned CW    = $clog2(BURST_LEN + 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BURST_LEN);
`ifdef FIFO_AUTO_DRAIN_EN
   localparam logic [LW-1:0] LVL_AUTO = LW'(DEPTH - 1);
`endif

   drain_state_t          state_q, state_d;
   logic [LW-1:0]         level_q, level_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  rd_en_q, rd_en_d;

   logic gnt0, gnt1, arb_en, wr_en, start;

   // Reset gating keeps the combinational grant path at 0 during reset
   assign arb_en = inReset & (level_q != LVL_FULL);

   rr_arbiter2 u_arb (
      .req0   (inReq0),
      .req1   (inReq1),
      .ptr    (ptr_q),
      .enable (arb_en),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign wr_en              = (inReq0 & gnt0) | (inReq1 & gnt1);
   assign outGnt0            = gnt0;
   assign outGnt1            = gnt1;
   assign outFifoWriteEnable = wr_en;
   assign outFifoData        = gnt0 ? inData0 : (gnt1 ? inData1 : '0);
   assign outFifoReadEnable  = rd_en_q;
   assign outData            = data_q;
   assign outValid           = valid_q;
   assign outDone            = done_q;
   assign outLevel           = level_q;
   assign outBusy            = (state_q != ST_IDLE);

   // Burst start condition from IDLE
   always_comb begin
`ifdef FIFO_AUTO_DRAIN_EN
      start = (level_q != '0) && (inDrainReq || (level_q >= LVL_AUTO));
`else
      start = inDrainReq && (level_q != '0);
`endif
   end

   // Pointer hands priority to the other requester after every transfer
   always_comb begin
      ptr_d = ptr_q;
      if (gnt0)      ptr_d = 1'b1;
      else if (gnt1) ptr_d = 1'b0;
   end

   // Occupancy: write increments, read strobe decrements, both hold
   always_comb begin
      level_d = level_q;
      unique case ({wr_en, rd_en_q})
         2'b10:   if (level_q != LVL_FULL) level_d = level_q + LW'(1);
         2'b01:   if (level_q != '0)       level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Drain FSM next state; WAIT looks at level_d so a concurrent write counts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      rd_en_d = 1'b0;
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_READ;
            cnt_d   = CNT_LOAD;
            rd_en_d = 1'b1;
         end
         ST_READ: state_d = ST_WAIT;
         ST_WAIT: begin
            data_d  = inFifoData;
            valid_d = 1'b1;
            cnt_d   = cnt_q - CW'(1);
            if ((cnt_d == '0) || (level_d == '0)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_READ;
               rd_en_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // All state and registered outputs; async reset aborts any burst
   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
      end
   end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: queue-based FIFO/arbitration/burst model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fifo_access_ctrl;

   localparam int DW = 4;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   localparam int BURST = 4;

   logic          clk;
   logic          inReset, inReq0, inReq1, inDrainReq;
   logic [DW-1:0] inData0, inData1, inFifoData;
   logic          outGnt0, outGnt1, outFifoWriteEnable, outFifoReadEnable;
   logic [DW-1:0] outFifoData, outData;
   logic          outValid, outDone, outBusy;
   logic [AW:0]   outLevel;

   fifo_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BURST)) dut (
      .inClock(clk), .inReset(inReset), .inReq0(inReq0), .inReq1(inReq1),
      .inData0(inData0), .inData1(inData1), .outGnt0(outGnt0), .outGnt1(outGnt1),
      .inDrainReq(inDrainReq), .outFifoWriteEnable(outFifoWriteEnable),
      .outFifoData(outFifoData), .outFifoReadEnable(outFifoReadEnable),
      .inFifoData(inFifoData), .outData(outData), .outValid(outValid),
      .outDone(outDone), .outLevel(outLevel), .outBusy(outBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model state: FIFO contents, arbitration owner, burst progress
   logic [DW-1:0] mem[$];
   int            mptr, bcyc, words, lvl;
   bit            m_valid, m_done, n_valid, n_done, eg0, eg1, e_rd, st;
   logic [DW-1:0] m_vdata, n_vdata, popped, rd_word;
   bit            rd_fire;

   // Observation logs
   int            cyc = 0;
   int            strobe_cyc[$];
   logic [DW-1:0] vals[$];
   int            done_cnt;
   bit            busy_seen;

   // External FIFO read port: data valid the cycle after the strobe
   always @(posedge clk) if (rd_fire) inFifoData <= rd_word;

   // Per-cycle compare against the model, then advance the model
   always @(negedge clk) begin
      cyc++;
      if (!inReset) begin
         check("reset_outputs", {outGnt0, outGnt1, outFifoWriteEnable, outFifoData,
               outFifoReadEnable, outData, outValid, outDone, outLevel, outBusy}, '0);
         mem.delete();
         mptr = 0; bcyc = 0; words = 0; m_valid = 0; m_done = 0; rd_fire = 0;
      end else begin
         lvl = mem.size();
         eg0 = (lvl != DEPTH) && inReq0 && (!inReq1 || mptr == 0);
         eg1 = (lvl != DEPTH) && inReq1 && (!inReq0 || mptr == 1);
         e_rd = (bcyc % 2) == 1;
         check("gnt0", outGnt0, eg0);
         check("gnt1", outGnt1, eg1);
         check("wr_en", outFifoWriteEnable, eg0 | eg1);
         if (eg0 | eg1) check("wr_data", outFifoData, eg0 ? inData0 : inData1);
         check("level", outLevel, lvl);
         check("rd_en", outFifoReadEnable, e_rd);
         check("valid", outValid, m_valid);
         if (m_valid) check("out_data", outData, m_vdata);
         check("done", outDone, m_done);
         check("busy", outBusy, (bcyc != 0) || m_done);

         if (outFifoReadEnable) strobe_cyc.push_back(cyc);
         if (outValid) vals.push_back(outData);
         if (outDone) done_cnt++;
         if (outBusy) busy_seen = 1;

         rd_fire = 0;
         if (e_rd && mem.size() > 0) begin
            rd_word = mem.pop_front();
            popped  = rd_word;
            rd_fire = 1;
         end
         if (eg0) mem.push_back(inData0);
         else if (eg1) mem.push_back(inData1);
         if (eg0) mptr = 1;
         else if (eg1) mptr = 0;

         n_valid = 0; n_done = 0; n_vdata = m_vdata;
`ifdef FIFO_AUTO_DRAIN_EN
         st = (lvl > 0) && (inDrainReq || lvl >= DEPTH - 1);
`else
         st = inDrainReq && (lvl > 0);
`endif
         if (bcyc == 0) begin
            if (!m_done && st) begin bcyc = 1; words = 0; end
         end else if ((bcyc % 2) == 1) begin
            bcyc++;
         end else begin
            words++;
            n_valid = 1;
            n_vdata = popped;
            if (words == BURST || mem.size() == 0) begin bcyc = 0; n_done = 1; end
            else bcyc++;
         end
         m_valid = n_valid; m_vdata = n_vdata; m_done = n_done;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      strobe_cyc.delete(); vals.delete(); done_cnt = 0; busy_seen = 0;
   endtask

   task automatic do_reset();
      inReset = 0; inReq0 = 0; inReq1 = 0; inDrainReq = 0;
      tick(); tick();
      inReset = 1;
   endtask

   task automatic write_one(input bit who, input logic [DW-1:0] d);
      if (who) begin inReq1 = 1; inData1 = d; end
      else     begin inReq0 = 1; inData0 = d; end
      tick();
      inReq0 = 0; inReq1 = 0;
   endtask

   task automatic drain_pulse();
      inDrainReq = 1; tick(); inDrainReq = 0;
   endtask

   logic [DW-1:0] exp3[4] = '{4'hF, 4'hE, 4'h5, 4'hA};

   initial begin
      inReset = 0; inReq0 = 0; inReq1 = 0; inDrainReq = 0;
      inData0 = '0; inData1 = '0; inFifoData = '0;
      clear_logs();

      // Reset held 5 cycles with a request present: no grant may leak
      tick(); tick();
      inReq0 = 1; inData0 = 4'h3;
      #1 check("rst_gnt_gated", outGnt0, 0);
      tick(); tick(); tick();

      // Single write of 0xB from requester 0
      inReset = 1; inReq0 = 1; inData0 = 4'hB;
      #1;
      check("t1_gnt0", outGnt0, 1);
      check("t1_gnt1", outGnt1, 0);
      check("t1_we", outFifoWriteEnable, 1);
      check("t1_wdata", outFifoData, 4'hB);
      tick();
      inReq0 = 0;
      check("t1_level", outLevel, 1);
      clear_logs();
      drain_pulse();
      repeat (8) tick();
      check("t1_drain_n", vals.size(), 1);
      check("t1_drain_d", vals[0], 4'hB);

      // Contention: grants alternate from requester 0 until full
      do_reset();
      inReq0 = 1; inReq1 = 1; inData0 = 4'hF; inData1 = 4'hE;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifndef FIFO_AUTO_DRAIN_EN
         check("t2_gnt0", outGnt0, (i % 2) == 0);
         check("t2_gnt1", outGnt1, (i % 2) == 1);
`endif
         tick();
      end
      #1;
`ifndef FIFO_AUTO_DRAIN_EN
      check("t2_level", outLevel, 4);
      check("t2_full_gnt", {outGnt0, outGnt1, outFifoWriteEnable}, 0);
`endif
      tick();
      inReq0 = 0; inReq1 = 0;

      // Full burst of four words
      do_reset();
      write_one(0, 4'hF); write_one(1, 4'hE); write_one(0, 4'h5); write_one(1, 4'hA);
`ifndef FIFO_AUTO_DRAIN_EN
      check("t3_level_pre", outLevel, 4);
      clear_logs();
      drain_pulse();
      repeat (14) tick();
      check("t3_strobes", strobe_cyc.size(), 4);
      for (int i = 1; i < 4; i++) check("t3_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
      check("t3_nvals", vals.size(), 4);
      for (int i = 0; i < 4; i++) check("t3_val", vals[i], exp3[i]);
      check("t3_done", done_cnt, 1);
      check("t3_level", outLevel, 0);
`else
      repeat (14) tick();
`endif

      // Early end of burst at level 2, then an ignored request at level 0
      do_reset();
      write_one(0, 4'h3); write_one(1, 4'hC);
      check("t4_level_pre", outLevel, 2);
      clear_logs();
      drain_pulse();
      repeat (10) tick();
      check("t4_nvals", vals.size(), 2);
      check("t4_val0", vals[0], 4'h3);
      check("t4_val1", vals[1], 4'hC);
      check("t4_done", done_cnt, 1);
      check("t4_strobes", strobe_cyc.size(), 2);
      check("t4_level", outLevel, 0);
      clear_logs();
      drain_pulse();
      for (int i = 0; i < 6; i++) begin
         check("t4_idle_busy", outBusy, 0);
         tick();
      end
      check("t4_no_strobe", strobe_cyc.size(), 0);

      // Reset asserted while waiting for read data
      do_reset();
      write_one(0, 4'h7); write_one(0, 4'h9);
      clear_logs();
      drain_pulse();
      for (int i = 0; i < 8 && !outFifoReadEnable; i++) tick();
      check("t5_read_seen", outFifoReadEnable, 1);
      tick();
      #2 inReset = 0;
      #1;
      check("t5_rst_outs", {outValid, outDone, outBusy, outFifoReadEnable,
            outLevel, outData, outFifoWriteEnable}, 0);
      tick(); tick();
      inReset = 1;
      repeat (6) tick();
      check("t5_no_done", done_cnt, 0);
      check("t5_no_valid", vals.size(), 0);
      check("t5_idle", outBusy, 0);

      // Auto-drain threshold at DEPTH-1
      do_reset();
      clear_logs();
      write_one(0, 4'h1); write_one(0, 4'h2); write_one(0, 4'h4);
      repeat (10) tick();
`ifdef FIFO_AUTO_DRAIN_EN
      check("t6_auto_busy", busy_seen, 1);
      check("t6_auto_vals", vals.size(), 3);
`else
      check("t6_no_burst", busy_seen, 0);
      check("t6_level", outLevel, 3);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
